// File: rtl/dataflow_perf_counter.sv
// Multi-channel ap_ctrl latency monitor: per-channel timestamp FIFOs pair accepts with
// completions and feed saturating count/sum/min/max statistics behind a registered readout.
module dataflow_perf_counter #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 4,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic              clear,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_ready,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [1:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] ovf,
  output logic [NUM_CH-1:0] unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W + 1)'(DEPTH);

  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t             ts_q, ts_d;
  cnt_t             fifo_q  [NUM_CH][DEPTH];
  logic [PTR_W-1:0] rptr_q  [NUM_CH];
  logic [PTR_W-1:0] rptr_d  [NUM_CH];
  logic [PTR_W-1:0] wptr_q  [NUM_CH];
  logic [PTR_W-1:0] wptr_d  [NUM_CH];
  logic [PTR_W:0]   occ_q   [NUM_CH];
  logic [PTR_W:0]   occ_d   [NUM_CH];
  cnt_t             count_q [NUM_CH];
  cnt_t             count_d [NUM_CH];
  cnt_t             sum_q   [NUM_CH];
  cnt_t             sum_d   [NUM_CH];
  cnt_t             min_q   [NUM_CH];
  cnt_t             min_d   [NUM_CH];
  cnt_t             max_q   [NUM_CH];
  cnt_t             max_d   [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d, unf_q, unf_d, push;
  cnt_t             rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             acc, cmp, empty, full, do_pop, do_push, bypass;
  cnt_t             lat;
  logic [CNT_W:0]   sum_ext;

  // Per-channel event decode; an accept meeting a completion on an empty FIFO bypasses it with lat 0.
  always_comb begin
    ts_d  = finish ? ts_q : ts_q + CNT_W'(1);
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rptr_d[i]  = rptr_q[i];
      wptr_d[i]  = wptr_q[i];
      occ_d[i]   = occ_q[i];
      count_d[i] = count_q[i];
      sum_d[i]   = sum_q[i];
      min_d[i]   = min_q[i];
      max_d[i]   = max_q[i];

      acc     = ap_start[i] & ap_ready[i];
      cmp     = ap_done[i] & ap_continue[i];
      empty   = (occ_q[i] == '0);
      full    = (occ_q[i] == FULL_OCC);
      do_pop  = cmp & ~empty;
      bypass  = cmp & empty & acc;
      do_push = acc & ~bypass & (~full | do_pop);
      lat     = bypass ? '0 : ts_q - fifo_q[i][rptr_q[i]];
      sum_ext = {1'b0, sum_q[i]} + {1'b0, lat};

      if (clear) begin
        rptr_d[i]  = '0;
        wptr_d[i]  = '0;
        occ_d[i]   = '0;
        count_d[i] = '0;
        sum_d[i]   = '0;
        min_d[i]   = '1;
        max_d[i]   = '0;
        ovf_d[i]   = 1'b0;
        unf_d[i]   = 1'b0;
      end else if (!finish) begin
        if (cmp && empty && !acc) unf_d[i] = 1'b1;
        if (acc && full && !do_pop) ovf_d[i] = 1'b1;
        if (do_pop) rptr_d[i] = rptr_q[i] + PTR_W'(1);
        if (do_push) begin
          wptr_d[i] = wptr_q[i] + PTR_W'(1);
          push[i]   = 1'b1;
        end
        if (do_push && !do_pop) occ_d[i] = occ_q[i] + (PTR_W + 1)'(1);
        else if (do_pop && !do_push) occ_d[i] = occ_q[i] - (PTR_W + 1)'(1);
        if (do_pop || bypass) begin
          count_d[i] = (count_q[i] == '1) ? count_q[i] : count_q[i] + CNT_W'(1);
          sum_d[i]   = sum_ext[CNT_W] ? '1 : sum_ext[CNT_W-1:0];
          if (lat < min_q[i]) min_d[i] = lat;
          if (lat > max_q[i]) max_d[i] = lat;
        end
      end
    end
  end

  // Readout samples the pre-update statistics; out-of-range channels read as zero.
  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      if (int'(rd_ch) < NUM_CH) begin
        case (rd_sel)
          2'd0: rd_data_d = count_q[rd_ch];
          2'd1: rd_data_d = sum_q[rd_ch];
          2'd2: rd_data_d = min_q[rd_ch];
          2'd3: rd_data_d = max_q[rd_ch];
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) fifo_q[i][wptr_q[i]] <= ts_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q       <= '0;
      ovf_q      <= '0;
      unf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        rptr_q[i]  <= '0;
        wptr_q[i]  <= '0;
        occ_q[i]   <= '0;
        count_q[i] <= '0;
        sum_q[i]   <= '0;
        min_q[i]   <= '1;
        max_q[i]   <= '0;
      end
    end else begin
      ts_q       <= ts_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      for (int i = 0; i < NUM_CH; i++) begin
        rptr_q[i]  <= rptr_d[i];
        wptr_q[i]  <= wptr_d[i];
        occ_q[i]   <= occ_d[i];
        count_q[i] <= count_d[i];
        sum_q[i]   <= sum_d[i];
        min_q[i]   <= min_d[i];
        max_q[i]   <= max_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) busy[i] = (occ_q[i] != '0);
  end

  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_dataflow_perf_counter.sv
// Bench for dataflow_perf_counter: directed scenarios plus random traffic checked against a
// queue-based latency model of each channel.
module tb_dataflow_perf_counter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 4;
  localparam int MAXV   = 255;

  logic              clock = 1'b0;
  logic              reset, finish, clear;
  logic [NUM_CH-1:0] ap_start, ap_ready, ap_done, ap_continue;
  logic              rd_en;
  logic [1:0]        rd_ch, rd_sel;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic [NUM_CH-1:0] busy, ovf, unf;

  int checks = 0;
  int fails  = 0;

  int mTs;
  int mQ[NUM_CH][$];
  int mCount[NUM_CH], mSum[NUM_CH], mMin[NUM_CH], mMax[NUM_CH];
  bit mOvf[NUM_CH], mUnf[NUM_CH];
  int mRdData;
  bit mRdValid;

  dataflow_perf_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .finish(finish), .clear(clear),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .ovf(ovf), .unf(unf)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int statOf(int ch, int sel);
    if (ch >= NUM_CH) return 0;
    case (sel)
      0: return mCount[ch];
      1: return mSum[ch];
      2: return mMin[ch];
      default: return mMax[ch];
    endcase
  endfunction

  task automatic modelClearStats();
    for (int i = 0; i < NUM_CH; i++) begin
      mQ[i].delete();
      mCount[i] = 0; mSum[i] = 0; mMin[i] = MAXV; mMax[i] = 0;
      mOvf[i] = 0; mUnf[i] = 0;
    end
  endtask

  task automatic modelReset();
    modelClearStats();
    mTs = 0; mRdData = 0; mRdValid = 0;
  endtask

  task automatic record(int i, int lat);
    mCount[i] = (mCount[i] + 1 > MAXV) ? MAXV : mCount[i] + 1;
    mSum[i]   = (mSum[i] + lat > MAXV) ? MAXV : mSum[i] + lat;
    if (lat < mMin[i]) mMin[i] = lat;
    if (lat > mMax[i]) mMax[i] = lat;
  endtask

  // Advance the model by one clock from the inputs currently driven, then let the DUT take the edge.
  task automatic tick();
    bit acc, cmp;
    if (rd_en) begin
      mRdData  = statOf(int'(rd_ch), int'(rd_sel));
      mRdValid = 1;
    end else mRdValid = 0;
    if (clear) modelClearStats();
    else if (!finish) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc = ap_start[i] && ap_ready[i];
        cmp = ap_done[i] && ap_continue[i];
        if (cmp) begin
          if (mQ[i].size() > 0) record(i, (mTs - mQ[i].pop_front()) & MAXV);
          else if (acc) begin record(i, 0); acc = 0; end
          else mUnf[i] = 1;
        end
        if (acc) begin
          if (mQ[i].size() < DEPTH) mQ[i].push_back(mTs);
          else mOvf[i] = 1;
        end
      end
    end
    if (!finish) mTs = (mTs + 1) & MAXV;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ap_start = '0; ap_ready = '0; ap_done = '0; ap_continue = '1;
    rd_en = 0; finish = 0; clear = 0;
  endtask

  task automatic doRead(int ch, int sel);
    rd_en = 1; rd_ch = 2'(ch); rd_sel = 2'(sel);
    tick();
    rd_en = 0;
  endtask

  task automatic accept(int ch);
    ap_start[ch] = 1; ap_ready[ch] = 1;
  endtask

  task automatic test_reset();
    reset = 1; idle(); rd_ch = 0; rd_sel = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    modelReset();
    checks++; if (busy !== 4'h0) begin fails++; $display("[TB] FAIL reset_busy got %h want 0", busy); end
    checks++; if (ovf !== 4'h0 || unf !== 4'h0) begin fails++; $display("[TB] FAIL reset_flags got ovf=%h unf=%h want 0", ovf, unf); end
    checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_rd got valid=%b data=%0d want 0/0", rd_valid, rd_data); end
    doRead(0, 2);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hFF) begin fails++; $display("[TB] FAIL reset_min got valid=%b data=%0d want 1/255", rd_valid, rd_data); end
  endtask

  task automatic test_single();
    int exp[4] = '{1, 15, 15, 15};
    accept(0); tick(); idle();
    checks++; if (busy[0] !== 1'b1) begin fails++; $display("[TB] FAIL single_busy got %b want 1", busy[0]); end
    repeat (14) tick();
    ap_done[0] = 1; tick(); idle();
    checks++; if (busy[0] !== 1'b0) begin fails++; $display("[TB] FAIL single_idle got %b want 0", busy[0]); end
    for (int s = 0; s < 4; s++) begin
      doRead(0, s);
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 8'(exp[s])) begin
        fails++; $display("[TB] FAIL single_sel%0d got valid=%b data=%0d want 1/%0d", s, rd_valid, rd_data, exp[s]);
      end
    end
    tick();
    checks++; if (rd_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_pulse got valid=%b want 0", rd_valid); end
  endtask

  task automatic test_pipelined();
    int exp[4] = '{3, 21, 7, 7};
    for (int t = 0; t < 12; t++) begin
      ap_start[1] = (t == 0 || t == 2 || t == 4);
      ap_ready[1] = ap_start[1];
      ap_done[1]  = (t == 7 || t == 9 || t == 11);
      tick();
      checks++;
      if (busy[1] !== (t < 11)) begin fails++; $display("[TB] FAIL pipe_busy t=%0d got %b want %b", t, busy[1], t < 11); end
    end
    idle();
    for (int s = 0; s < 4; s++) begin
      doRead(1, s);
      checks++;
      if (rd_data !== 8'(exp[s])) begin fails++; $display("[TB] FAIL pipe_sel%0d got %0d want %0d", s, rd_data, exp[s]); end
    end
  endtask

  task automatic test_overflow();
    for (int t = 0; t < 5; t++) begin
      accept(2); tick();
      checks++;
      if (ovf[2] !== (t == 4)) begin fails++; $display("[TB] FAIL ovf_flag t=%0d got %b want %b", t, ovf[2], t == 4); end
    end
    idle();
    checks++; if (busy[2] !== 1'b1) begin fails++; $display("[TB] FAIL ovf_busy got %b want 1", busy[2]); end
    for (int t = 0; t < 4; t++) begin ap_done[2] = 1; tick(); end
    idle();
    checks++; if (busy[2] !== 1'b0 || unf[2] !== 1'b0) begin fails++; $display("[TB] FAIL ovf_drain got busy=%b unf=%b want 0/0", busy[2], unf[2]); end
    ap_done[2] = 1; tick(); idle();
    checks++; if (unf[2] !== 1'b1) begin fails++; $display("[TB] FAIL unf_flag got %b want 1", unf[2]); end
    doRead(2, 0);
    checks++; if (rd_data !== 8'd4) begin fails++; $display("[TB] FAIL ovf_count got %0d want 4", rd_data); end
    doRead(2, 1);
    checks++; if (rd_data !== 8'd20) begin fails++; $display("[TB] FAIL ovf_sum got %0d want 20", rd_data); end
  endtask

  task automatic test_same_cycle();
    int exp[4] = '{1, 0, 0, 0};
    accept(3); ap_done[3] = 1; tick(); idle();
    checks++; if (busy[3] !== 1'b0 || unf[3] !== 1'b0) begin fails++; $display("[TB] FAIL bypass_flags got busy=%b unf=%b want 0/0", busy[3], unf[3]); end
    for (int s = 0; s < 4; s++) begin
      doRead(3, s);
      checks++;
      if (rd_data !== 8'(exp[s])) begin fails++; $display("[TB] FAIL bypass_sel%0d got %0d want %0d", s, rd_data, exp[s]); end
    end
  endtask

  task automatic test_wrap_finish();
    int guard = 0;
    clear = 1; tick(); clear = 0;
    while (mTs != 250 && guard < 300) begin tick(); guard++; end
    accept(0); accept(1); tick(); idle();
    while (mTs != 4 && guard < 600) begin tick(); guard++; end
    ap_done[0] = 1; tick(); idle();
    finish = 1;
    for (int t = 0; t < 20; t++) begin
      ap_start[2] = (t % 3 == 0); ap_ready[2] = ap_start[2];
      ap_done[3] = (t == 5);
      rd_en = (t == 10); rd_ch = 0; rd_sel = 2;
      tick();
      if (t == 10) begin
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'd10) begin fails++; $display("[TB] FAIL wrap_min got valid=%b data=%0d want 1/10", rd_valid, rd_data); end
      end
    end
    idle();
    checks++; if (busy !== 4'b0010 || unf[3] !== 1'b0) begin fails++; $display("[TB] FAIL finish_frozen got busy=%b unf3=%b want 0010/0", busy, unf[3]); end
    ap_done[1] = 1; tick(); idle();
    doRead(1, 3);
    checks++; if (rd_data !== 8'd11) begin fails++; $display("[TB] FAIL finish_ts_hold got %0d want 11", rd_data); end
    doRead(0, 1);
    checks++; if (rd_data !== 8'd10) begin fails++; $display("[TB] FAIL wrap_sum got %0d want 10", rd_data); end
  endtask

  task automatic test_async_reset_clear();
    int exp[4] = '{0, 0, 255, 0};
    accept(0); tick(); idle(); tick();
    ap_done[3] = 1; tick(); idle();
    checks++; if (unf[3] !== 1'b1 || busy[0] !== 1'b1) begin fails++; $display("[TB] FAIL pre_reset got unf3=%b busy0=%b want 1/1", unf[3], busy[0]); end
    #2 reset = 1;
    #1;
    checks++; if (busy !== 4'h0 || ovf !== 4'h0 || unf !== 4'h0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      fails++; $display("[TB] FAIL async_reset got busy=%h ovf=%h unf=%h valid=%b data=%0d want all 0", busy, ovf, unf, rd_valid, rd_data);
    end
    modelReset();
    @(posedge clock); #1 reset = 0;
    clear = 1; tick(); clear = 0;
    for (int s = 0; s < 4; s++) begin
      doRead(0, s);
      checks++;
      if (rd_data !== 8'(exp[s])) begin fails++; $display("[TB] FAIL clear_sel%0d got %0d want %0d", s, rd_data, exp[s]); end
    end
    accept(0); tick(); idle(); tick(); tick();
    ap_done[0] = 1; tick(); idle();
    doRead(0, 2);
    checks++; if (rd_data !== 8'd3) begin fails++; $display("[TB] FAIL post_clear_min got %0d want 3", rd_data); end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] expBusy, expOvf, expUnf;
    for (int n = 0; n < 800; n++) begin
      ap_start    = NUM_CH'($urandom);
      ap_ready    = NUM_CH'($urandom);
      ap_done     = NUM_CH'($urandom) & NUM_CH'($urandom);
      ap_continue = NUM_CH'($urandom) | NUM_CH'($urandom);
      rd_en       = 1'($urandom);
      rd_ch       = 2'($urandom);
      rd_sel      = 2'($urandom);
      finish      = ($urandom_range(0, 15) == 0);
      clear       = ($urandom_range(0, 99) == 0);
      tick();
      for (int i = 0; i < NUM_CH; i++) begin
        expBusy[i] = (mQ[i].size() > 0);
        expOvf[i]  = mOvf[i];
        expUnf[i]  = mUnf[i];
      end
      checks++;
      if (busy !== expBusy || ovf !== expOvf || unf !== expUnf) begin
        fails++; $display("[TB] FAIL rand_flags n=%0d got busy=%b ovf=%b unf=%b want %b/%b/%b", n, busy, ovf, unf, expBusy, expOvf, expUnf);
      end
      checks++;
      if (rd_valid !== mRdValid || rd_data !== 8'(mRdData)) begin
        fails++; $display("[TB] FAIL rand_rd n=%0d got valid=%b data=%0d want %b/%0d", n, rd_valid, rd_data, mRdValid, mRdData);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_pipelined();
    test_overflow();
    test_same_cycle();
    test_wrap_finish();
    test_async_reset_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dataflow_perf_counter.md
Name: dataflow_perf_counter

Overview:
Synthesizable, multi-channel successor to the simulation-only dataflow status monitor. It observes the ap_ctrl handshakes of NUM_CH HLS modules and measures per-transaction start-to-done latency, including overlapped (pipelined) transactions, using a per-channel timestamp FIFO. Results are accumulated into per-channel statistics, read through a registered readout port, and frozen on the testbench or system finish signal.

Parameters:
NUM_CH, 4, number of monitored module channels (>=1)
CNT_W, 32, width of the timestamp, latency and statistic counters (>=8)
DEPTH, 4, per-channel outstanding-start FIFO depth (power of 2, >=2)

Ports:
clock  in  1  single clock; all state updates on its rising edge
reset  in  1  asynchronous, active-high reset
finish  in  1  level-high freezes the timestamp counter and all statistics
clear  in  1  synchronous clear of statistics, FIFOs and sticky flags
ap_start  in  NUM_CH  per-channel module ap_start
ap_ready  in  NUM_CH  per-channel module ap_ready
ap_done  in  NUM_CH  per-channel module ap_done
ap_continue  in  NUM_CH  per-channel ap_continue; tie high for modules without it
rd_en  in  1  readout request
rd_ch  in  max(1,$clog2(NUM_CH))  channel to read
rd_sel  in  2  0=txn count, 1=latency sum, 2=min latency, 3=max latency
rd_data  out  CNT_W  registered readout data
rd_valid  out  1  rd_data valid, one-cycle pulse
busy  out  NUM_CH  channel FIFO is non-empty (transaction in flight)
ovf  out  NUM_CH  sticky: start accepted while FIFO was full
unf  out  NUM_CH  sticky: done seen with no outstanding start

Behaviour:
- Reset (async assert): timestamp=0; FIFOs empty; count=0; sum=0; min=all-ones; max=0; ovf=unf=0; rd_data=0; rd_valid=0.
- Timestamp: free-running CNT_W counter, increments every cycle unless finish=1. Wraps modulo 2^CNT_W.
- Accept event on channel i: ap_start[i] & ap_ready[i]. Push the current timestamp onto FIFO i.
- Completion event on channel i: ap_done[i] & ap_continue[i]. Pop the oldest timestamp T. lat = (timestamp - T) mod 2^CNT_W, which is correct across a single wrap.
- Stats update on completion, applied on the next edge:
  - count += 1, saturating at all-ones.
  - sum += lat, saturating at all-ones.
  - min = min(min, lat); max = max(max, lat).
- Accept and completion in the same cycle:
  - FIFO non-empty: pop the oldest entry and push the new one; occupancy unchanged.
  - FIFO empty: bypass, recording lat=0; FIFO stays empty.
- FIFO full and accept without a same-cycle pop: drop the push and set ovf[i]. A later completion still pairs with the oldest stored entry.
- FIFO empty and completion with no same-cycle accept: no stats update; set unf[i].
- finish=1: no pushes, pops, stat updates or flag updates; timestamp holds. Readout still works.
- clear=1: same effect as reset but synchronous, and takes priority over events in that cycle. The timestamp is not cleared.
- Readout: when rd_en=1, on the next edge rd_data = stat[rd_ch][rd_sel] and rd_valid=1; otherwise rd_valid=0 and rd_data holds.
  - Reads see the stat values before any same-cycle update.
  - rd_ch >= NUM_CH returns 0 with rd_valid=1.
  - Min with count=0 reads all-ones.
- busy[i] reflects FIFO occupancy > 0 after each edge.
- Channels are fully independent; there is no arbitration between them.

Test Plan:
- Single txn on ch0: accept at t=10, done at t=25, then read rd_sel 0..3 -> count=1, sum=15, min=15, max=15; rd_valid one cycle after each rd_en.
- Pipelined ch1: accepts at t=0,2,4, dones at t=7,9,11 -> count=3, sum=21, min=7, max=7; busy[1] high over t=1..11.
- Overflow with DEPTH=4 on ch2: 5 accepts with no done -> ovf[2]=1, busy[2]=1; 4 dones -> count=4, busy[2]=0; 5th done -> unf[2]=1.
- Same-cycle accept+done on an empty ch3 -> count=1, min=0, max=0, unf[3]=0.
- Wrap with CNT_W=8: accept at timestamp 250, done at timestamp 4 -> lat=10; finish=1 for 20 cycles freezes the timestamp and stats, and readout still returns 10.
- Async reset asserted mid-transaction, then clear pulsed -> all stats at reset values, min=all-ones, busy=0, flags=0; a following txn of lat 3 gives min=3.
